// File: rtl/ram8_32bit_multiplier.sv
// ram8_32bit_multiplier
//
// Storage-plus-arithmetic block for the expression memory chip.
//   * RAM8_32BIT : 8 words x 32 bits, single port, synchronous, with a
//                  registered read-data output. Reset clears every word.
//   * MULTIPLIER : purely combinational 32 x 32 unsigned multiplier built
//                  as a 32-row shift-and-add partial-product array.
// The two halves are not connected internally. The enclosing controller
// routes out0 to xm/ym and routes out back to in.
//
// Ports
//   clk      in   1   rising-edge clock for the RAM
//   rst      in   1   synchronous active-high reset (clears RAM and out0)
//   en       in   1   RAM enable; no RAM action when 0
//   rw       in   1   1 = write, 0 = read
//   address  in   3   word address 0..7
//   in       in  32   RAM write data
//   out0     out 32   registered RAM read data
//   xm       in  32   multiplier operand A
//   ym       in  32   multiplier operand B
//   out      out 32   low 32 bits of xm * ym
//   ovf      out  1   1 when bits [63:32] of the full product are nonzero
module ram8_32bit_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rw,
  input  logic [2:0]  address,
  input  logic [31:0] in,
  output logic [31:0] out0,
  input  logic [31:0] xm,
  input  logic [31:0] ym,
  output logic [31:0] out,
  output logic        ovf
);

  localparam int unsigned WORDS = 8;

  // ---------------------------------------------------------------------
  // RAM8_32BIT
  // ---------------------------------------------------------------------
  logic [31:0] mem_q  [0:WORDS-1];
  logic [31:0] mem_d  [0:WORDS-1];
  logic [31:0] out0_q;
  logic [31:0] out0_d;

  // Next-state for storage and read register: rst beats en, rw picks the op.
  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      mem_d[i] = mem_q[i];
    end
    out0_d = out0_q;
    if (rst) begin
      // A write presented together with reset is discarded.
      for (int i = 0; i < WORDS; i++) begin
        mem_d[i] = 32'h0000_0000;
      end
      out0_d = 32'h0000_0000;
    end else if (en) begin
      if (rw) begin
        // Write leaves out0 untouched.
        mem_d[address] = in;
      end else begin
        out0_d = mem_q[address];
      end
    end else begin
      // Idle: everything holds.
      out0_d = out0_q;
    end
  end

  // Storage and read-data registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORDS; i++) begin
      mem_q[i] <= mem_d[i];
    end
    out0_q <= out0_d;
  end

  assign out0 = out0_q;

  // ---------------------------------------------------------------------
  // MULTIPLIER
  // ---------------------------------------------------------------------
  // acc_s[k] holds the sum of the first k partial products; row k adds
  // xm shifted left by k when bit k of ym is set. acc_s[32] is the full
  // 64-bit product, which can never exceed 64 bits for 32 x 32 operands.
  logic [63:0] acc_s [0:32];

  assign acc_s[0] = 64'h0;

  for (genvar gi = 0; gi < 32; gi++) begin : g_row
    logic [63:0] row_s;
    assign row_s        = ym[gi] ? ({32'h0, xm} << gi) : 64'h0;
    assign acc_s[gi+1]  = acc_s[gi] + row_s;
  end

  assign out = acc_s[32][31:0];
  assign ovf = |acc_s[32][63:32];

endmodule

// File: tb/tb_ram8_32bit_multiplier.sv
module tb_ram8_32bit_multiplier;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rw;
  logic [2:0]  address;
  logic [31:0] in_v;
  logic [31:0] out0;
  logic [31:0] xm;
  logic [31:0] ym;
  logic [31:0] out;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  // behavioural model
  logic [31:0] m_mem [0:7];
  logic [31:0] m_out0;
  bit          m_valid = 1'b0;

  ram8_32bit_multiplier dut (
    .clk(clk), .rst(rst), .en(en), .rw(rw), .address(address),
    .in(in_v), .out0(out0), .xm(xm), .ym(ym), .out(out), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model update on each rising edge (inputs change 2 time units after edges)
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 32'h0;
      m_out0  = 32'h0;
      m_valid = 1'b1;
    end else if (en && rw) begin
      m_mem[address] = in_v;
    end else if (en) begin
      m_out0 = m_mem[address];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic [63:0] p;
    p = {32'h0, xm} * {32'h0, ym};
    check("mul_out", {32'h0, out}, {32'h0, p[31:0]});
    check("mul_ovf", {63'h0, ovf}, {63'h0, (p[63:32] != 32'h0)});
    if (m_valid) check("out0_model", {32'h0, out0}, {32'h0, m_out0});
  end

  // apply one edge with the given inputs; return 2 units after that edge
  task automatic op(input logic r, input logic e, input logic w,
                    input logic [2:0] a, input logic [31:0] d);
    rst = r; en = e; rw = w; address = a; in_v = d;
    @(posedge clk); #2;
  endtask

  task automatic mul_lit(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eo, input logic eovf);
    xm = a; ym = b; #1;
    check("mul_lit_out", {32'h0, out}, {32'h0, eo});
    check("mul_lit_ovf", {63'h0, ovf}, {63'h0, eovf});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; en = 1'b0; rw = 1'b0; address = 3'd0; in_v = 32'h0;
    xm = 32'h0; ym = 32'h0;
    @(posedge clk); #2;
    op(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    op(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    check("reset_out0", {32'h0, out0}, 64'h0);

    // reset clear
    for (int a = 0; a < 8; a++) op(1'b0, 1'b1, 1'b1, 3'(a), 32'hDEADBEEF);
    op(1'b0, 1'b1, 1'b0, 3'd4, 32'h0);
    check("pre_reset_read", {32'h0, out0}, 64'hDEADBEEF);
    op(1'b1, 1'b0, 1'b0, 3'd0, 32'h0);
    check("reset_pulse_out0", {32'h0, out0}, 64'h0);
    for (int a = 0; a < 8; a++) begin
      op(1'b0, 1'b1, 1'b0, 3'(a), 32'h0);
      check("reset_clear_read", {32'h0, out0}, 64'h0);
    end

    // write/read each address, read back in reverse
    for (int a = 0; a < 8; a++) begin
      op(1'b0, 1'b1, 1'b1, 3'(a), 32'h11111111 * 32'(a + 1));
      check("write_holds_out0", {32'h0, out0}, 64'h0);
    end
    for (int a = 7; a >= 0; a--) begin
      op(1'b0, 1'b1, 1'b0, 3'(a), 32'h0);
      check("rev_read", {32'h0, out0}, {32'h0, 32'h11111111 * 32'(a + 1)});
    end

    // enable gating
    op(1'b0, 1'b0, 1'b1, 3'd3, 32'hFFFFFFFF);
    check("en0_write_out0", {32'h0, out0}, 64'h11111111);
    op(1'b0, 1'b0, 1'b0, 3'd6, 32'h0);
    check("en0_read_hold", {32'h0, out0}, 64'h11111111);
    op(1'b0, 1'b1, 1'b0, 3'd3, 32'h0);
    check("en0_mem3_kept", {32'h0, out0}, 64'h44444444);

    // expression flow
    op(1'b0, 1'b1, 1'b1, 3'd0, 32'd7);
    op(1'b0, 1'b1, 1'b1, 3'd1, 32'd6);
    op(1'b0, 1'b1, 1'b0, 3'd0, 32'h0);
    xm = out0;
    op(1'b0, 1'b1, 1'b0, 3'd1, 32'h0);
    ym = out0;
    #1;
    check("expr_out", {32'h0, out}, 64'd42);
    check("expr_ovf", {63'h0, ovf}, 64'h0);
    op(1'b0, 1'b1, 1'b1, 3'd2, out);
    op(1'b0, 1'b1, 1'b0, 3'd2, 32'h0);
    check("expr_read2", {32'h0, out0}, 64'd42);

    // multiplier truncation
    mul_lit(32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    mul_lit(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    mul_lit(32'h00000000, 32'hA5A5A5A5, 32'h00000000, 1'b0);
    mul_lit(32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0);
    mul_lit(32'h80000000, 32'h00000002, 32'h00000000, 1'b1);
    mul_lit(32'h12345678, 32'h00000010, 32'h23456780, 1'b1);

    // multiplier is unaffected by reset
    rst = 1'b1; #1;
    check("mul_during_rst", {32'h0, out}, 64'h23456780);

    // reset priority over a simultaneous write
    op(1'b0, 1'b1, 1'b1, 3'd5, 32'hCAFEF00D);
    op(1'b1, 1'b1, 1'b1, 3'd5, 32'h12345678);
    op(1'b0, 1'b1, 1'b0, 3'd5, 32'h0);
    check("rst_priority", {32'h0, out0}, 64'h0);

    op(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
